uart_tx_cfg: RTL
================

// Module: uart_tx_cfg
// PURPOSE
//   Parametrised UART transmitter. Sends one serial frame per accepted word:
//   start bit, 5..DBIT_MAX data bits LSB-first, optional parity, 1 or 2 stop bits.
//   Frame format is selected at run time and latched per frame. Uses a
//   ready/valid handshake. Driven by the shared baud generator's s_tick.
// PARAMETERS
//   DBIT_MAX  8   widest data word supported (>=5); width of tx_data
//   SB_TICK   16  s_tick pulses per serial bit period (>=2)
// PORTS
//   clk         in   1          system clock; all logic on rising edge
//   rst_n       in   1          asynchronous reset, active low
//   s_tick      in   1          oversample tick, one clk wide
//   tx_valid    in   1          tx_data/cfg_* valid, frame requested
//   tx_ready    out  1          block idle, can accept a frame
//   tx_data     in   DBIT_MAX   data word; bit 0 is sent first
//   cfg_dbits   in   4          data bits per frame, 5..DBIT_MAX
//   cfg_parity  in   2          00 none, 01 even, 10 odd, 11 none (reserved)
//   cfg_stop2   in   1          0 = one stop bit, 1 = two stop bits
//   busy        out  1          frame in progress (START..STOP)
//   tx_done_tick out 1          one-clk pulse when the frame completes
//   tx          out  1          serial line, registered, idle high
// BEHAVIOUR
//   Reset (rst_n low, asynchronous): state IDLE, tx=1, tx_done_tick=0, busy=0,
//     tx_ready=1, all counters and shift registers 0. A frame in flight is
//     abandoned with no done pulse. tx returns high immediately.
//   Handshake: tx_ready = (state==IDLE). A frame is accepted on the rising edge
//     where tx_valid && tx_ready. On that edge the block latches tx_data,
//     cfg_dbits, cfg_parity and cfg_stop2, and computes the parity bit.
//     cfg_* and tx_data changes after acceptance have no effect on the frame.
//   cfg_dbits clamp: <5 is used as 5; >DBIT_MAX is used as DBIT_MAX.
//   Parity: P = XOR of the used data bits. Even parity sends P; odd parity sends ~P.
//   FSM: IDLE -> START -> DATA -> (PARITY if enabled) -> STOP -> IDLE.
//     - On the accept edge: state START, tx<=0, tick counter s<=0.
//     - Each bit lasts exactly SB_TICK s_ticks. s increments on each s_tick.
//       The bit ends on the s_tick seen when s==SB_TICK-1. On that edge s<=0,
//       the next state/bit is registered, and tx is updated on the same edge.
//     - DATA: tx=shift[0]. At bit end, shift right; after bit cfg_dbits-1,
//       go to PARITY or STOP.
//     - PARITY: one bit period, tx=parity bit.
//     - STOP: tx=1 for SB_TICK ticks, or 2*SB_TICK ticks if stop2.
//       The stop-bit count is kept internally.
//   Completion: on the edge ending the last stop tick, state<=IDLE, and
//     tx_done_tick is registered high for exactly one clk. tx_ready rises on
//     that same edge. With tx_valid held high, the next frame is accepted on
//     the following edge, so tx stays high for exactly one clk between frames.
//   s_tick in IDLE is ignored. When s_tick is low, no counter moves and tx holds.
//   busy = ~tx_ready. tx_done_tick is never asserted outside completion.
//   Frame length in s_ticks = SB_TICK*(1 + dbits + par + stop), where
//     par = 1 if parity is enabled, else 0, and stop = 1 or 2.
// TESTING  (DBIT_MAX=8, SB_TICK=16, s_tick every clk unless noted)
//   8N1, tx_data=0xA5 -> tx bits 0,1,0,1,0,0,1,0,1,1, each held 16 clk;
//     tx_done_tick after 160 ticks.
//   7E1, 0x41 -> 0,1,0,0,0,0,0,1, parity 0, stop 1;
//     cfg_dbits=3 with 0x07 -> frame sent as 5 data bits 1,1,1,0,0.
//   5O2, 0x1F -> data 1,1,1,1,1, parity 0, stop high for 32 ticks; total 144 ticks.
//   tx_valid held high, two words -> one clk of tx=1 between frames;
//     change cfg_* mid-frame -> current frame unchanged.
//   s_tick once every 4 clk -> every bit lasts 64 clk; counters frozen
//     between ticks.
//   rst_n low during DATA bit 3 -> tx=1 at once, no tx_done_tick, tx_ready=1;
//     next frame is correct.

Source files
------------

// File: rtl/uart_tx_cfg_if.sv
// Frame request handshake between a word source and the configurable UART transmitter.
// The source drives the data word and frame format; the transmitter returns ready.
interface uart_tx_cfg_if #(
    parameter int DBIT_MAX = 8
);
    logic                tx_valid;
    logic                tx_ready;
    logic [DBIT_MAX-1:0] tx_data;
    logic [3:0]          cfg_dbits;
    logic [1:0]          cfg_parity;
    logic                cfg_stop2;

    modport master (
        output tx_valid, tx_data, cfg_dbits, cfg_parity, cfg_stop2,
        input  tx_ready
    );

    modport slave (
        input  tx_valid, tx_data, cfg_dbits, cfg_parity, cfg_stop2,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_cfg.sv
// UART transmitter with run-time frame format (5..DBIT_MAX data bits, parity, 1/2 stop).
// Format and data are latched when a frame is accepted; bit timing comes from s_tick.
module uart_tx_cfg #(
    parameter int DBIT_MAX = 8,
    parameter int SB_TICK  = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_tick,
    uart_tx_cfg_if.slave  bus,
    output logic          busy,
    output logic          tx_done_tick,
    output logic          tx
);
    localparam int         SW     = $clog2(SB_TICK);
    localparam logic [SW-1:0] S_LAST = SW'(SB_TICK - 1);
    localparam logic [3:0] D_MIN  = 4'd5;
    localparam logic [3:0] D_MAX  = 4'(DBIT_MAX);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e              state_q, state_d;
    logic [SW-1:0]       s_q, s_d;
    logic [3:0]          n_q, n_d;
    logic [3:0]          dbits_q, dbits_d;
    logic [DBIT_MAX-1:0] shift_q, shift_d;
    logic                par_en_q, par_en_d;
    logic                par_bit_q, par_bit_d;
    logic                stop2_q, stop2_d;
    logic                stop_cnt_q, stop_cnt_d;
    logic                tx_q, tx_d;
    logic                done_q, done_d;

    logic [3:0]          dbits_eff;
    logic                par_calc;
    logic                bit_end;

    // Clamp the requested width and fold only the bits that will actually be sent.
    always_comb begin
        dbits_eff = bus.cfg_dbits;
        if (bus.cfg_dbits < D_MIN)      dbits_eff = D_MIN;
        else if (bus.cfg_dbits > D_MAX) dbits_eff = D_MAX;
        par_calc = 1'b0;
        for (int i = 0; i < DBIT_MAX; i++) begin
            if (4'(i) < dbits_eff) par_calc = par_calc ^ bus.tx_data[i];
        end
    end

    assign bit_end = s_tick && (s_q == S_LAST);

    always_comb begin
        // NOTE: every target gets a default first so no path leaves a value unassigned (no latches).
        state_d    = state_q;
        s_d        = s_q;
        n_d        = n_q;
        dbits_d    = dbits_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        stop2_d    = stop2_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;
        done_d     = 1'b0;

        if (state_q != IDLE && s_tick && !bit_end) s_d = s_q + 1'b1;
        if (bit_end) s_d = '0;

        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (bus.tx_valid) begin
                    state_d   = START;
                    tx_d      = 1'b0;
                    s_d       = '0;
                    n_d       = '0;
                    dbits_d   = dbits_eff;
                    shift_d   = bus.tx_data;
                    par_en_d  = (bus.cfg_parity == 2'b01) || (bus.cfg_parity == 2'b10);
                    par_bit_d = (bus.cfg_parity == 2'b10) ? ~par_calc : par_calc;
                    stop2_d   = bus.cfg_stop2;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    n_d     = '0;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (n_q == dbits_q - 4'd1) begin
                        state_d    = par_en_q ? PARITY : STOP;
                        tx_d       = par_en_q ? par_bit_q : 1'b1;
                        stop_cnt_d = 1'b0;
                    end else begin
                        n_d  = n_q + 4'd1;
                        tx_d = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d    = STOP;
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop2_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            state_q    <= IDLE;
            s_q        <= '0;
            n_q        <= '0;
            dbits_q    <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            n_q        <= n_d;
            dbits_q    <= dbits_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
        end
    end

    assign bus.tx_ready  = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign tx            = tx_q;
    assign tx_done_tick  = done_q;
endmodule
